// File: rtl/riscv_pkg.sv
// riscv_pkg -- shared RISC-V constants for the fetch/decode boundary.
//   XLEN_DEFAULT / ILEN_DEFAULT : default PC and instruction widths
//   NOP                         : canonical ADDI x0,x0,0 encoding
//   OPC_*                       : RV64I base opcodes (instruction[6:0])
//   is_rv64i_opcode()           : 1 when a 7-bit opcode is an RV64I base opcode
package riscv_pkg;

   localparam int XLEN_DEFAULT = 64;
   localparam int ILEN_DEFAULT = 32;

   localparam logic [31:0] NOP = 32'h0000_0013;

   localparam logic [6:0] OPC_LOAD      = 7'b000_0011;
   localparam logic [6:0] OPC_STORE     = 7'b010_0011;
   localparam logic [6:0] OPC_OP        = 7'b011_0011;
   localparam logic [6:0] OPC_OP_IMM    = 7'b001_0011;
   localparam logic [6:0] OPC_OP_32     = 7'b011_1011;
   localparam logic [6:0] OPC_OP_IMM_32 = 7'b001_1011;
   localparam logic [6:0] OPC_BRANCH    = 7'b110_0011;
   localparam logic [6:0] OPC_JAL       = 7'b110_1111;
   localparam logic [6:0] OPC_JALR      = 7'b110_0111;
   localparam logic [6:0] OPC_LUI       = 7'b011_0111;
   localparam logic [6:0] OPC_AUIPC     = 7'b001_0111;
   localparam logic [6:0] OPC_SYSTEM    = 7'b111_0011;
   localparam logic [6:0] OPC_MISC_MEM  = 7'b000_1111;

   // Membership test against the RV64I base opcode map.
   function automatic logic is_rv64i_opcode(input logic [6:0] opc);
      logic hit;
      case (opc)
         OPC_LOAD, OPC_STORE, OPC_OP, OPC_OP_IMM, OPC_OP_32, OPC_OP_IMM_32,
         OPC_BRANCH, OPC_JAL, OPC_JALR, OPC_LUI, OPC_AUIPC, OPC_SYSTEM,
         OPC_MISC_MEM: hit = 1'b1;
         default:      hit = 1'b0;
      endcase
      return hit;
   endfunction

endpackage

// File: rtl/rv_predecode.sv
// rv_predecode -- field slicing and illegal-opcode flag for the decode head.
//   i_valid       : head entry valid
//   i_instruction : head instruction word
//   o_opcode/o_rd/o_rs1/o_rs2/o_funct3/o_funct7 : standard RV field slices
//   o_illegal     : valid and (not a 32-bit encoding or not an RV64I opcode)
module rv_predecode
   import riscv_pkg::*;
#(
   parameter int ILEN = ILEN_DEFAULT
) (
   input  logic            i_valid,
   input  logic [ILEN-1:0] i_instruction,
   output logic [6:0]      o_opcode,
   output logic [4:0]      o_rd,
   output logic [4:0]      o_rs1,
   output logic [4:0]      o_rs2,
   output logic [2:0]      o_funct3,
   output logic [6:0]      o_funct7,
   output logic [0:0]      o_illegal
);

   assign o_opcode = i_instruction[6:0];
   assign o_rd     = i_instruction[11:7];
   assign o_funct3 = i_instruction[14:12];
   assign o_rs1    = i_instruction[19:15];
   assign o_rs2    = i_instruction[24:20];
   assign o_funct7 = i_instruction[31:25];

   // Compressed encodings (low bits != 11) are not supported by this core.
   assign o_illegal = i_valid &
                      ((i_instruction[1:0] != 2'b11) | ~is_rv64i_opcode(i_instruction[6:0]));

endmodule

// File: rtl/if_id_stage.sv
// if_id_stage -- fetch-to-decode pipeline register built as a 2-entry skid
// buffer (main entry drives id_*, skid entry absorbs one beat of backpressure).
//   clk, reset (sync, active-high)
//   if_valid/if_pc/if_instruction/if_ready : fetch-side handshake
//   id_valid/id_pc/id_instruction/id_ready : decode-side handshake
//   flush : drop every held beat and any same-cycle incoming beat
// Optional: define IF_ID_PREDECODE_EN to add id_opcode, id_rd, id_rs1, id_rs2,
// id_funct3, id_funct7 and id_illegal sliced from the main entry.
module if_id_stage
   import riscv_pkg::*;
#(
   parameter int XLEN = XLEN_DEFAULT,
   parameter int ILEN = ILEN_DEFAULT
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            if_valid,
   input  logic [XLEN-1:0] if_pc,
   input  logic [ILEN-1:0] if_instruction,
   output logic            if_ready,
   input  logic            flush,
   output logic            id_valid,
   output logic [XLEN-1:0] id_pc,
   output logic [ILEN-1:0] id_instruction,
`ifdef IF_ID_PREDECODE_EN
   output logic [6:0]      id_opcode,
   output logic [4:0]      id_rd,
   output logic [4:0]      id_rs1,
   output logic [4:0]      id_rs2,
   output logic [2:0]      id_funct3,
   output logic [6:0]      id_funct7,
   output logic [0:0]      id_illegal,
`endif
   input  logic            id_ready
);

   logic            r_main_valid;
   logic [XLEN-1:0] r_main_pc;
   logic [ILEN-1:0] r_main_instr;
   logic            r_skid_valid;
   logic [XLEN-1:0] r_skid_pc;
   logic [ILEN-1:0] r_skid_instr;

   logic            w_accept;
   logic            w_consume;

   // Ready depends only on the skid flag (and reset), never on id_ready.
   assign if_ready  = ~r_skid_valid & ~reset;
   assign w_accept  = if_valid & if_ready;
   assign w_consume = r_main_valid & id_ready;

   assign id_valid       = r_main_valid;
   assign id_pc          = r_main_pc;
   assign id_instruction = r_main_valid ? r_main_instr : ILEN'(NOP);

   // Skid-buffer state: flush beats everything except reset; PC registers are
   // only written on a data move so id_pc holds its last value when empty.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_main_valid <= 1'b0;
         r_main_pc    <= '0;
         r_main_instr <= '0;
         r_skid_valid <= 1'b0;
         r_skid_pc    <= '0;
         r_skid_instr <= '0;
      end else if (flush) begin
         r_main_valid <= 1'b0;
         r_skid_valid <= 1'b0;
      end else if (r_skid_valid) begin
         // Full: no accept possible; a consume promotes skid into main.
         if (w_consume) begin
            r_main_pc    <= r_skid_pc;
            r_main_instr <= r_skid_instr;
            r_skid_valid <= 1'b0;
         end else begin
            r_skid_valid <= 1'b1;
         end
      end else if (r_main_valid && !w_consume) begin
         // Main is stalled: a new beat parks in the skid entry.
         if (w_accept) begin
            r_skid_pc    <= if_pc;
            r_skid_instr <= if_instruction;
            r_skid_valid <= 1'b1;
         end else begin
            r_skid_valid <= 1'b0;
         end
      end else begin
         // Main empty or draining this edge: new beat goes straight to main.
         if (w_accept) begin
            r_main_pc    <= if_pc;
            r_main_instr <= if_instruction;
            r_main_valid <= 1'b1;
         end else begin
            r_main_valid <= 1'b0;
         end
      end
   end

`ifdef IF_ID_PREDECODE_EN
   rv_predecode #(
      .ILEN          (ILEN)
   ) u_predecode (
      .i_valid       (r_main_valid),
      .i_instruction (r_main_instr),
      .o_opcode      (id_opcode),
      .o_rd          (id_rd),
      .o_rs1         (id_rs1),
      .o_rs2         (id_rs2),
      .o_funct3      (id_funct3),
      .o_funct7      (id_funct7),
      .o_illegal     (id_illegal)
   );
`endif

endmodule

// File: tb/tb_if_id_stage.sv
// tb_if_id_stage -- directed self-checking bench for if_id_stage.
// Inputs change 1 time unit after a rising edge; outputs are checked there too.
module tb_if_id_stage;

   logic        clk = 1'b0;
   logic        reset;
   logic        if_valid;
   logic [63:0] if_pc;
   logic [31:0] if_instruction;
   logic        if_ready;
   logic        flush;
   logic        id_valid;
   logic [63:0] id_pc;
   logic [31:0] id_instruction;
   logic        id_ready;
`ifdef IF_ID_PREDECODE_EN
   logic [6:0]  id_opcode;
   logic [4:0]  id_rd;
   logic [4:0]  id_rs1;
   logic [4:0]  id_rs2;
   logic [2:0]  id_funct3;
   logic [6:0]  id_funct7;
   logic [0:0]  id_illegal;
`endif

   int tests_run = 0;
   int tests_failed = 0;

   always #5 clk = ~clk;

   if_id_stage #(.XLEN(64), .ILEN(32)) dut (
      .clk            (clk),
      .reset          (reset),
      .if_valid       (if_valid),
      .if_pc          (if_pc),
      .if_instruction (if_instruction),
      .if_ready       (if_ready),
      .flush          (flush),
      .id_valid       (id_valid),
      .id_pc          (id_pc),
      .id_instruction (id_instruction),
`ifdef IF_ID_PREDECODE_EN
      .id_opcode      (id_opcode),
      .id_rd          (id_rd),
      .id_rs1         (id_rs1),
      .id_rs2         (id_rs2),
      .id_funct3      (id_funct3),
      .id_funct7      (id_funct7),
      .id_illegal     (id_illegal),
`endif
      .id_ready       (id_ready)
   );

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [63:0] pc, input logic [31:0] ins);
      if_valid       = v;
      if_pc          = pc;
      if_instruction = ins;
   endtask

   initial begin
      reset = 1'b1; flush = 1'b0; id_ready = 1'b0;
      drive(1'b0, 64'h0, 32'h0);

      // Reset state
      tick();
      check_val("rst_id_valid", 64'(id_valid), 64'h0);
      check_val("rst_id_pc", id_pc, 64'h0);
      check_val("rst_id_instr", 64'(id_instruction), 64'h13);
      check_val("rst_if_ready", 64'(if_ready), 64'h0);
      reset = 1'b0;
      #1;
      check_val("post_rst_if_ready", 64'(if_ready), 64'h1);

      // Streaming with decode always ready
      id_ready = 1'b1;
      drive(1'b1, 64'h0, 32'h0010_0093);
      tick();
      check_val("s0_pc", id_pc, 64'h0);
      check_val("s0_instr", 64'(id_instruction), 64'h0010_0093);
      check_val("s0_if_ready", 64'(if_ready), 64'h1);
      drive(1'b1, 64'h4, 32'h0020_0113);
      tick();
      check_val("s1_pc", id_pc, 64'h4);
      check_val("s1_valid", 64'(id_valid), 64'h1);
      check_val("s1_if_ready", 64'(if_ready), 64'h1);
      drive(1'b1, 64'h8, 32'h0030_0193);
      tick();
      check_val("s2_pc", id_pc, 64'h8);
      check_val("s2_instr", 64'(id_instruction), 64'h0030_0193);
      check_val("s2_if_ready", 64'(if_ready), 64'h1);
      drive(1'b0, 64'h0, 32'h0);
      tick();
      check_val("empty_valid", 64'(id_valid), 64'h0);
      check_val("empty_nop", 64'(id_instruction), 64'h13);
      check_val("empty_pc_hold", id_pc, 64'h8);

      // Backpressure into the skid entry
      id_ready = 1'b0;
      drive(1'b1, 64'h10, 32'h0040_0213);
      tick();
      check_val("bp0_pc", id_pc, 64'h10);
      check_val("bp0_if_ready", 64'(if_ready), 64'h1);
      drive(1'b1, 64'h14, 32'h0050_0293);
      tick();
      check_val("bp1_if_ready", 64'(if_ready), 64'h0);
      check_val("bp1_pc", id_pc, 64'h10);
      drive(1'b1, 64'h18, 32'h0060_0313);  // must be ignored while full
      tick();
      check_val("bp2_pc_stable", id_pc, 64'h10);
      check_val("bp2_instr_stable", 64'(id_instruction), 64'h0040_0213);
      drive(1'b0, 64'h0, 32'h0);
      id_ready = 1'b1;
      tick();
      check_val("bp3_pc", id_pc, 64'h14);
      check_val("bp3_instr", 64'(id_instruction), 64'h0050_0293);
      check_val("bp3_if_ready", 64'(if_ready), 64'h1);
      tick();
      check_val("bp4_valid", 64'(id_valid), 64'h0);
      check_val("bp4_pc_hold", id_pc, 64'h14);

      // Flush beats a same-cycle accept
      id_ready = 1'b0;
      drive(1'b1, 64'h20, 32'h0070_0393);
      tick();
      check_val("fl0_pc", id_pc, 64'h20);
      drive(1'b1, 64'h24, 32'h0080_0413);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      drive(1'b0, 64'h0, 32'h0);
      check_val("fl1_valid", 64'(id_valid), 64'h0);
      check_val("fl1_nop", 64'(id_instruction), 64'h13);
      check_val("fl1_if_ready", 64'(if_ready), 64'h1);
      id_ready = 1'b1;
      tick();
      check_val("fl2_valid", 64'(id_valid), 64'h0);
      check_val("fl2_pc", id_pc, 64'h20);

      // Reset with both entries full
      id_ready = 1'b0;
      drive(1'b1, 64'h30, 32'h0090_0493);
      tick();
      drive(1'b1, 64'h34, 32'h00A0_0513);
      tick();
      check_val("rm_full_if_ready", 64'(if_ready), 64'h0);
      drive(1'b0, 64'h0, 32'h0);
      reset = 1'b1;
      tick();
      check_val("rm_valid", 64'(id_valid), 64'h0);
      check_val("rm_pc", id_pc, 64'h0);
      check_val("rm_if_ready", 64'(if_ready), 64'h0);
      reset = 1'b0;
      #1;
      check_val("rm_if_ready_after", 64'(if_ready), 64'h1);
      id_ready = 1'b1;
      tick();
      check_val("rm_still_empty", 64'(id_valid), 64'h0);

`ifdef IF_ID_PREDECODE_EN
      check_val("pd_empty_illegal", 64'(id_illegal), 64'h0);
      drive(1'b1, 64'h40, 32'h00A2_8293);
      tick();
      check_val("pd_opcode", 64'(id_opcode), 64'h13);
      check_val("pd_rd", 64'(id_rd), 64'h5);
      check_val("pd_rs1", 64'(id_rs1), 64'h5);
      check_val("pd_funct3", 64'(id_funct3), 64'h0);
      check_val("pd_legal", 64'(id_illegal), 64'h0);
      drive(1'b1, 64'h44, 32'h0000_0000);
      tick();
      check_val("pd_zero_illegal", 64'(id_illegal), 64'h1);
      drive(1'b0, 64'h0, 32'h0);
      tick();
`endif

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/if_id_stage.md
IF_ID_STAGE -- requirements
Module: if_id_stage

Interface
REQ-001 Parameter XLEN, default 64, PC width in bits.
REQ-002 Parameter ILEN, default 32, instruction width in bits.
REQ-003 The block SHALL have one clock and a synchronous, active-high reset, named clk and reset.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 reset  input  1  synchronous active-high reset.
REQ-006 if_valid  input  1  fetch presents a valid instruction this cycle.
REQ-007 if_pc  input  XLEN  PC of the presented instruction.
REQ-008 if_instruction  input  ILEN  fetched instruction word.
REQ-009 if_ready  output  1  stage accepts the fetch beat this cycle.
REQ-010 flush  input  1  discard all held instructions (branch/jump redirect).
REQ-011 id_valid  output  1  decode-side beat valid.
REQ-012 id_pc  output  XLEN  PC of the head instruction.
REQ-013 id_instruction  output  ILEN  head instruction word.
REQ-014 id_ready  input  1  decode consumes the head beat this cycle.

Function
REQ-015 Storage SHALL be a 2-entry skid buffer: main register (drives id_*) plus skid register.
REQ-016 A beat SHALL be accepted when if_valid && if_ready, and consumed when id_valid && id_ready.
REQ-017 if_ready SHALL equal !skid_valid && !reset, a function of registered state only (no combinational path from id_ready).
REQ-018 Latency SHALL be 1 cycle: a beat accepted at edge N is visible on id_* after edge N when the main register is empty or being consumed.
REQ-019 Accept while the main register is full and not consumed SHALL write the skid register.
REQ-020 Consume while skid is full SHALL move skid to main at the same edge; a new accept is not possible then (if_ready=0).
REQ-021 Simultaneous accept and consume with skid empty SHALL replace main with the new beat; order SHALL be strictly FIFO.
REQ-022 Full (both entries valid): if_ready=0; held data SHALL remain stable until consumed.
REQ-023 Empty: id_valid=0, id_instruction SHALL drive 32'h00000013 (NOP), id_pc SHALL hold its last value.
REQ-024 flush SHALL clear both valid bits at the next edge and take priority over a same-cycle accept (the incoming beat is dropped) and consume.
REQ-025 Data SHALL pass unmodified; no width conversion of PC or instruction.

Reset
REQ-026 When reset is high at a clock edge, both entries SHALL be invalidated; id_valid=0, id_pc=0, id_instruction=NOP, if_ready=0 during reset.
REQ-027 Reset mid-operation SHALL discard held beats; if_ready SHALL return to 1 on the first cycle with reset low.

Configuration
REQ-028 Macro IF_ID_PREDECODE_EN SHALL, when defined, add outputs id_opcode[6:0], id_rd[4:0], id_rs1[4:0], id_rs2[4:0], id_funct3[2:0], id_funct7[6:0], id_illegal[0], combinationally sliced from the main register.
REQ-029 id_illegal SHALL be 1 when id_valid and (instruction[1:0] != 2'b11 or opcode not an RV64I opcode); 0 otherwise.
REQ-030 Without IF_ID_PREDECODE_EN these ports and their logic SHALL be absent; core behaviour is identical.

Structure
REQ-031 Package riscv_pkg SHALL hold XLEN/ILEN defaults, the NOP constant, and RV64I opcode constants (LOAD, STORE, OP, OP_IMM, OP_32, OP_IMM_32, BRANCH, JAL, JALR, LUI, AUIPC, SYSTEM, MISC_MEM).
REQ-032 One sub-module rv_predecode (slicing plus illegal check), instantiated only under IF_ID_PREDECODE_EN.

Verification
REQ-033 Streaming: id_ready=1, beats PC 0x0,0x4,0x8 on consecutive cycles -> id_pc 0x0,0x4,0x8 one cycle later each, if_ready stays 1.
REQ-034 Backpressure: id_ready=0, send PC 0x10,0x14 -> if_ready=0 after second accept, id_pc=0x10 stable; raise id_ready -> 0x10 then 0x14 delivered, if_ready returns 1.
REQ-035 Flush priority: main holds 0x20, if_valid with 0x24 and flush same cycle -> next cycle id_valid=0, id_instruction=0x00000013, 0x24 never delivered.
REQ-036 Reset mid-stream: both entries full, assert reset one edge -> id_valid=0, id_pc=0, if_ready=0 during reset, 1 after.
REQ-037 Predecode (macro defined): instruction 0x00A28293 -> opcode 0x13, rd 5, rs1 5, funct3 0, id_illegal=0; instruction 0x00000000 -> id_illegal=1.
